vga_scaled_scanout: RTL and testbench

Parametrised VGA scan-out engine that generates raster timing, fetches pixels from a dual-port frame buffer at a reduced source resolution, and replicates each source pixel SCALE×SCALE on screen. It sits between the frame-buffer read port (i_Rd_Clk/i_Rd_Addr/i_Rd_En/o_Rd_DV/o_Rd_Data) and the VGA pins, and replaces fixed-geometry controllers with one block that handles arbitrary timing, scale factor, read latency and built-in test patterns. All internal address arithmetic is exact, so no address bit-slicing is needed outside the block.

---
 rtl/vga_scaled_scanout.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vga_scaled_scanout.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_scanout.sv
// VGA scan-out engine: raster timing, scaled frame-buffer fetch with
// SCALE x SCALE pixel replication, built-in test patterns and underrun
// detection. Every output is delayed LAT = RD_LAT + 2 cycles from the
// raster counters, so geometry is the same in every mode.
module vga_scaled_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 2,
  parameter int PIX_W    = 12,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b0,
  parameter logic [PIX_W-1:0] SOLID_COLOR = 12'hF0F,
  parameter int AW = $clog2((H_ACTIVE / SCALE) * (V_ACTIVE / SCALE))
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  output logic             r_clk,
  output logic [AW-1:0]    r_addr,
  output logic             r_en,
  input  logic [PIX_W-1:0] r_data,
  input  logic             r_dv,
  output logic [3:0]       red_bits,
  output logic [3:0]       green_bits,
  output logic [3:0]       blue_bits,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SUBW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SRC_W   = H_ACTIVE / SCALE;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int LAT     = RD_LAT + 2;

  // Raster counters and source-address walkers
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [SUBW-1:0] h_sub_q, h_sub_d, v_sub_q, v_sub_d;
  logic [AW-1:0]   src_col_q, src_col_d, line_base_q, line_base_d;
  logic [1:0]      mode_q, mode_eff;

  logic h_last, v_last, h_act, v_act, active, frame_origin;
  logic hs_lvl, vs_lvl;
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] pat_color;

  // Stage-1 registers (read request) and delay line for stages 1..LAT-1
  logic [AW-1:0]    r_addr_q;
  logic             r_en_q;
  logic             de_pq  [1:LAT-1];
  logic             hs_pq  [1:LAT-1];
  logic             vs_pq  [1:LAT-1];
  logic             fs_pq  [1:LAT-1];
  logic             buf_pq [1:LAT-1];
  logic [PIX_W-1:0] pat_pq [1:LAT-1];

  // Output stage
  logic [PIX_W-1:0] color_q, color_d;
  logic             de_q, hs_q, vs_q, fs_q, underrun_q, underrun_d, set_ur;

  assign h_last       = (h_cnt_q == HW'(H_TOTAL - 1));
  assign v_last       = (v_cnt_q == VW'(V_TOTAL - 1));
  assign h_act        = (h_cnt_q < HW'(H_ACTIVE));
  assign v_act        = (v_cnt_q < VW'(V_ACTIVE));
  assign active       = h_act & v_act;
  assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  // The frame's mode is taken from the input at the origin cycle itself
  assign mode_eff     = frame_origin ? mode : mode_q;
  assign hs_lvl = ((h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                   (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign vs_lvl = ((v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                   (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;

  // Next-state for the raster counters and the division-free address walk
  always_comb begin
    h_cnt_d     = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    h_sub_d     = h_sub_q;
    v_sub_d     = v_sub_q;
    src_col_d   = src_col_q;
    line_base_d = line_base_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
    if (h_last && v_last) begin
      h_sub_d     = '0;
      v_sub_d     = '0;
      src_col_d   = '0;
      line_base_d = '0;
    end else begin
      if (active) begin
        if (h_cnt_q == HW'(H_ACTIVE - 1)) begin
          // Last visible pixel: rewind the column, step the source line
          // only once every SCALE screen lines.
          h_sub_d   = '0;
          src_col_d = '0;
          if (v_sub_q == SUBW'(SCALE - 1)) begin
            v_sub_d     = '0;
            line_base_d = line_base_q + AW'(SRC_W);
          end else begin
            v_sub_d = v_sub_q + 1'b1;
          end
        end else if (h_sub_q == SUBW'(SCALE - 1)) begin
          h_sub_d   = '0;
          src_col_d = src_col_q + 1'b1;
        end else begin
          h_sub_d = h_sub_q + 1'b1;
        end
      end
      if (h_last) begin
        h_sub_d   = '0;
        src_col_d = '0;
      end
    end
  end

  // Raster counter, address walker and frame-mode registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_sub_q     <= '0;
      v_sub_q     <= '0;
      src_col_q   <= '0;
      line_base_q <= '0;
      mode_q      <= 2'd0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_sub_q     <= h_sub_d;
      v_sub_q     <= v_sub_d;
      src_col_q   <= src_col_d;
      line_base_q <= line_base_d;
      if (frame_origin) mode_q <= mode;
    end
  end

  // Test-pattern colour for the current counter position
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= HW'(i * BAR_W)) bar_idx = 3'(i);
    end
    pat_color = '0;
    case (mode_eff)
      2'd1: pat_color = {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
      2'd2: pat_color = (h_cnt_q[5] ^ v_cnt_q[5]) ? 12'h000 : 12'hFFF;
      2'd3: pat_color = SOLID_COLOR;
      default: pat_color = '0;
    endcase
  end

  // Stage 1: issue the read and enter the timing/pattern delay line
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q  <= '0;
      r_en_q    <= 1'b0;
      de_pq[1]  <= 1'b0;
      hs_pq[1]  <= ~SYNC_POL;
      vs_pq[1]  <= ~SYNC_POL;
      fs_pq[1]  <= 1'b0;
      buf_pq[1] <= 1'b0;
      pat_pq[1] <= '0;
    end else begin
      r_en_q <= active && (mode_eff == 2'd0);
      if (active && (mode_eff == 2'd0)) r_addr_q <= line_base_q + src_col_q;
      de_pq[1]  <= active;
      hs_pq[1]  <= hs_lvl;
      vs_pq[1]  <= vs_lvl;
      fs_pq[1]  <= frame_origin;
      buf_pq[1] <= (mode_eff == 2'd0);
      pat_pq[1] <= pat_color;
    end
  end

  // Stages 2..LAT-1 mirror the frame-buffer read latency
  for (genvar gi = 2; gi < LAT; gi++) begin : g_stage
    // Shift one delay-line stage
    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        de_pq[gi]  <= 1'b0;
        hs_pq[gi]  <= ~SYNC_POL;
        vs_pq[gi]  <= ~SYNC_POL;
        fs_pq[gi]  <= 1'b0;
        buf_pq[gi] <= 1'b0;
        pat_pq[gi] <= '0;
      end else begin
        de_pq[gi]  <= de_pq[gi-1];
        hs_pq[gi]  <= hs_pq[gi-1];
        vs_pq[gi]  <= vs_pq[gi-1];
        fs_pq[gi]  <= fs_pq[gi-1];
        buf_pq[gi] <= buf_pq[gi-1];
        pat_pq[gi] <= pat_pq[gi-1];
      end
    end
  end

  // Final pixel selection; a missing r_dv in buffer mode shows SOLID_COLOR
  always_comb begin
    color_d = '0;
    set_ur  = 1'b0;
    if (de_pq[LAT-1]) begin
      if (buf_pq[LAT-1]) begin
        if (r_dv) begin
          color_d = r_data;
        end else begin
          color_d = SOLID_COLOR;
          set_ur  = 1'b1;
        end
      end else begin
        color_d = pat_pq[LAT-1];
      end
    end
    underrun_d = (fs_pq[LAT-1] ? 1'b0 : underrun_q) | set_ur;
  end

  // Output registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      color_q    <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      color_q    <= color_d;
      de_q       <= de_pq[LAT-1];
      hs_q       <= hs_pq[LAT-1];
      vs_q       <= vs_pq[LAT-1];
      fs_q       <= fs_pq[LAT-1];
      underrun_q <= underrun_d;
    end
  end

  assign r_clk       = pclk;
  assign r_addr      = r_addr_q;
  assign r_en        = r_en_q;
  assign red_bits    = color_q[11:8];
  assign green_bits  = color_q[7:4];
  assign blue_bits   = color_q[3:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_scaled_scanout.sv
// Bench for vga_scaled_scanout on a reduced raster. Expected outputs are
// computed from the screen position of each cycle with plain arithmetic;
// a latency-accurate RAM model answers the read port.
module tb_vga_scaled_scanout;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSY = 3, VBP = 3;
  localparam int SC = 4, RD_LAT = 3, PIX_W = 12;
  localparam int HT = HA + HFP + HSY + HBP;   // 80
  localparam int VT = VA + VFP + VSY + VBP;   // 56
  localparam int FRAME = HT * VT;             // 4480
  localparam int LAT = RD_LAT + 2;
  localparam int SRCW = HA / SC;
  localparam int NADDR = (HA / SC) * (VA / SC); // 192
  localparam int AW = $clog2(NADDR);
  localparam int SOLID = 'hF0F;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             r_clk;
  logic [AW-1:0]    r_addr;
  logic             r_en;
  logic [PIX_W-1:0] r_data = '0;
  logic             r_dv = 1'b0;
  logic [3:0]       red_bits, green_bits, blue_bits;
  logic             hsync, vsync, de, frame_start, underrun;

  always #5 pclk = ~pclk;

  vga_scaled_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SCALE(SC), .PIX_W(PIX_W), .RD_LAT(RD_LAT), .SYNC_POL(1'b0),
    .SOLID_COLOR(12'hF0F)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .mode(mode),
    .r_clk(r_clk), .r_addr(r_addr), .r_en(r_en),
    .r_data(r_data), .r_dv(r_dv),
    .red_bits(red_bits), .green_bits(green_bits), .blue_bits(blue_bits),
    .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .underrun(underrun)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;
  int max_addr = -1;
  bit exp_under = 1'b0;
  int mode_of_frame[int];
  int mode_sched[int];
  bit drop_at[int];
  int hist_en[0:RD_LAT];
  int hist_addr[0:RD_LAT];
  int hist_t[0:RD_LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  function automatic int data_of(input int a);
    return ((a * 37) ^ 'h5A3) & 'hFFF;
  endfunction

  function automatic bit is_active(input int t);
    return ((t % HT) < HA) && (((t / HT) % VT) < VA);
  endfunction

  function automatic int bar_color(input int b);
    case (b)
      0: return 'hFFF;
      1: return 'hFF0;
      2: return 'h0FF;
      3: return 'h0F0;
      4: return 'hF0F;
      5: return 'hF00;
      6: return 'h00F;
      default: return 'h000;
    endcase
  endfunction

  // Expected colour of the active pixel scanned at counter time t
  function automatic int exp_pix(input int t);
    int x, y, m;
    x = t % HT;
    y = (t / HT) % VT;
    m = mode_of_frame[t / FRAME];
    case (m)
      0: return drop_at.exists(t) ? SOLID : data_of((y / SC) * SRCW + x / SC);
      1: return bar_color(x / (HA / 8));
      2: return (((x >> 5) ^ (y >> 5)) & 1) ? 'h000 : 'hFFF;
      default: return SOLID;
    endcase
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_de"}, de, 0);
    check({pfx, "_rgb"}, {red_bits, green_bits, blue_bits}, 0);
    check({pfx, "_hsync"}, hsync, 1);
    check({pfx, "_vsync"}, vsync, 1);
    check({pfx, "_fs"}, frame_start, 0);
    check({pfx, "_underrun"}, underrun, 0);
    check({pfx, "_ren"}, r_en, 0);
    check({pfx, "_raddr"}, r_addr, 0);
  endtask

  // One cycle at the falling edge: compare, drive stimulus, run RAM model
  task automatic cycle_body();
    int t, t1, x, y, x1, y1;
    bit act, exp_en;
    t = n - LAT;
    if (t < 0) begin
      check("de", de, 0);
      check("hsync", hsync, 1);
      check("vsync", vsync, 1);
      check("frame_start", frame_start, 0);
      check("rgb", {red_bits, green_bits, blue_bits}, 0);
      check("underrun", underrun, 0);
    end else begin
      x = t % HT;
      y = (t / HT) % VT;
      act = is_active(t);
      if (t % FRAME == 0) exp_under = 1'b0;
      if (act && mode_of_frame[t / FRAME] == 0 && drop_at.exists(t)) exp_under = 1'b1;
      check("de", de, act);
      check("hsync", hsync, (x >= HA + HFP && x < HA + HFP + HSY) ? 0 : 1);
      check("vsync", vsync, (y >= VA + VFP && y < VA + VFP + VSY) ? 0 : 1);
      check("frame_start", frame_start, (t % FRAME == 0));
      check("rgb", {red_bits, green_bits, blue_bits}, act ? exp_pix(t) : 0);
      check("underrun", underrun, exp_under);
      if (t % FRAME == 0)
        $display("frame %0d mode=%0d", t / FRAME, mode_of_frame[t / FRAME]);
    end
    t1 = n - 1;
    exp_en = (t1 >= 0) && is_active(t1) && (mode_of_frame[t1 / FRAME] == 0);
    check("r_en", r_en, exp_en);
    if (exp_en) begin
      x1 = t1 % HT;
      y1 = (t1 / HT) % VT;
      check("r_addr", r_addr, (y1 / SC) * SRCW + x1 / SC);
    end
    if (r_en && int'(r_addr) > max_addr) max_addr = int'(r_addr);
    if (mode_sched.exists(n)) mode = 2'(mode_sched[n]);
    if (n % FRAME == 0) mode_of_frame[n / FRAME] = int'(mode);
    for (int k = RD_LAT; k > 0; k--) begin
      hist_en[k]   = hist_en[k-1];
      hist_addr[k] = hist_addr[k-1];
      hist_t[k]    = hist_t[k-1];
    end
    hist_en[0]   = int'(r_en);
    hist_addr[0] = int'(r_addr);
    hist_t[0]    = n - 1;
    r_dv   = (hist_en[RD_LAT] != 0) && !drop_at.exists(hist_t[RD_LAT]);
    r_data = PIX_W'(data_of(hist_addr[RD_LAT]));
  endtask

  // Mode schedule: plan[f] is present at the origin of frame f, with a
  // random mid-frame change that must be ignored; optional pixel drops.
  task automatic plan_frames(input int plan[], input int want_drop[]);
    int nf, x, y;
    nf = plan.size();
    mode_sched.delete();
    drop_at.delete();
    mode_of_frame.delete();
    for (int f = 0; f < nf; f++) begin
      mode_sched[f * FRAME + $urandom_range(100, FRAME - 300)] = $urandom_range(0, 3);
      if (f + 1 < nf)
        mode_sched[(f + 1) * FRAME - $urandom_range(1, 200)] = plan[f + 1];
      if (plan[f] == 0) begin
        for (int d = 0; d < want_drop[f]; d++) begin
          x = $urandom_range(0, HA - 1);
          y = $urandom_range(0, VA - 1);
          drop_at[f * FRAME + y * HT + x] = 1'b1;
        end
      end
    end
    for (int k = 0; k <= RD_LAT; k++) begin
      hist_en[k] = 0;
      hist_addr[k] = 0;
      hist_t[k] = -100;
    end
    exp_under = 1'b0;
  endtask

  task automatic run_from_release(input int start_mode, input int cycles);
    mode = 2'(start_mode);
    @(negedge pclk);
    rst_n = 1'b1;
    n = 0;
    cycle_body();
    for (int c = 1; c < cycles; c++) begin
      @(negedge pclk);
      n++;
      cycle_body();
    end
  endtask

  initial begin
    int plan1[], drop1[], plan2[], drop2[];
    plan1 = new[9];
    drop1 = new[9];
    plan1[0] = 0; drop1[0] = 0;
    plan1[1] = 1; drop1[1] = 0;
    plan1[2] = 0; drop1[2] = 1;
    plan1[3] = 0; drop1[3] = 0;
    plan1[4] = 2; drop1[4] = 0;
    plan1[5] = 3; drop1[5] = 0;
    for (int f = 6; f < 8; f++) begin
      plan1[f] = $urandom_range(0, 3);
      drop1[f] = $urandom_range(0, 2);
    end
    plan1[8] = 1; drop1[8] = 0;

    repeat (3) @(negedge pclk);
    check_reset_values("por");
    plan_frames(plan1, drop1);
    // Stop in frame 8, line 2, mid active area with colour bars showing
    run_from_release(plan1[0], 8 * FRAME + 2 * HT + 20);
    check("max_addr", max_addr, NADDR - 1);
    check("pre_reset_de", de, 1);

    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge pclk);
    check_reset_values("held_rst");

    plan2 = new[2];
    drop2 = new[2];
    plan2[0] = 0; drop2[0] = 1;
    plan2[1] = 2; drop2[1] = 0;
    plan_frames(plan2, drop2);
    run_from_release(plan2[0], 2 * FRAME + LAT + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
